// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-ported RAM between the
// fetch stage (IF, reads only) and the memory stage (MEM, loads and stores).
// MEM has priority over IF. Each transfer is one IDLE grant, WAIT_CYCLES
// ACCESS cycles and one RESP cycle that carries the owner's done pulse.
// Optional feature macro: MEM_PORT_ARB_STATS_EN adds a saturating 16-bit
// conflict_cnt output that counts grants made while both requesters were active.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef MEM_PORT_ARB_STATS_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);

  // A zero-cycle RAM access cannot be sequenced; refuse to build it.
  generate
    if (WAIT_CYCLES < 1) begin : g_bad_wait_cycles
      $error("mem_port_arbiter: WAIT_CYCLES must be >= 1");
    end
  endgenerate

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              own_mem_q, own_mem_d;   // 1: MEM owns the transfer, 0: IF
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_err_q, d_err_d;
  logic              mem_req;
`ifdef MEM_PORT_ARB_STATS_EN
  logic [15:0]       conflict_cnt_q, conflict_cnt_d;
`endif

  assign mem_req = d_rd | d_wr;

  // Next-state and next-output computation for the IDLE/ACCESS/RESP sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    own_mem_d  = own_mem_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ram_en_d   = ram_en_q;
    ram_we_d   = ram_we_q;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    d_err_d    = d_err_q;
`ifdef MEM_PORT_ARB_STATS_EN
    conflict_cnt_d = conflict_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          // The MEM-stage instruction is older, so it wins; rd+wr together acts as a store.
          own_mem_d = 1'b1;
          we_d      = d_wr;
          addr_d    = d_addr;
          wdata_d   = d_wdata;
          cnt_d     = CNT_LOAD;
          ram_en_d  = 1'b1;
          ram_we_d  = d_wr;
          state_d   = S_ACCESS;
          if (d_rd && d_wr) begin
            d_err_d = 1'b1;
          end
`ifdef MEM_PORT_ARB_STATS_EN
          if (if_req && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
          end
`endif
        end else if (if_req) begin
          own_mem_d = 1'b0;
          we_d      = 1'b0;
          addr_d    = if_addr;
          cnt_d     = CNT_LOAD;
          ram_en_d  = 1'b1;
          ram_we_d  = 1'b0;
          state_d   = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          // Last access cycle: RAM data is valid now, hand it to the owner.
          ram_en_d = 1'b0;
          ram_we_d = 1'b0;
          state_d  = S_RESP;
          if (own_mem_q) begin
            d_done_d = 1'b1;
            if (!we_q) begin
              d_rdata_d = ram_rdata;
            end
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = ram_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        // Requests seen here are ignored; the requester still holds them in IDLE.
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        ram_en_d = 1'b0;
        ram_we_d = 1'b0;
      end
    endcase
  end

  // Register all state and outputs; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      own_mem_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      d_err_q    <= 1'b0;
`ifdef MEM_PORT_ARB_STATS_EN
      conflict_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      own_mem_q  <= own_mem_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ram_en_q   <= ram_en_d;
      ram_we_q   <= ram_we_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      d_err_q    <= d_err_d;
`ifdef MEM_PORT_ARB_STATS_EN
      conflict_cnt_q <= conflict_cnt_d;
`endif
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign stall_if  = if_req & ~if_done_q;
  assign stall_mem = mem_req & ~d_done_q;
`ifdef MEM_PORT_ARB_STATS_EN
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a WAIT_CYCLES=2 instance checked every
// cycle against a transaction-timing model plus directed literal checks, and
// a WAIT_CYCLES=1 instance exercised with a held fetch request.
module tb_mem_port_arbiter;

  localparam int W = 2;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        stall_if;
  logic        stall_mem;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
`ifdef MEM_PORT_ARB_STATS_EN
  logic [15:0] conflict_cnt;
  logic [15:0] conflict_cnt1;
`endif

  logic        rst1;
  logic        if_req1;
  logic        if_done1;
  logic [31:0] if_rdata1;
  logic        d_done1;
  logic [31:0] d_rdata1;
  logic        d_err1;
  logic        stall_if1;
  logic        stall_mem1;
  logic        ram_en1;
  logic        ram_we1;
  logic [31:0] ram_addr1;
  logic [31:0] ram_wdata1;

  int n_checks = 0;
  int n_errors = 0;
  bit w1_done  = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef MEM_PORT_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst1),
    .if_req(if_req1), .if_addr(32'h10), .if_done(if_done1), .if_rdata(if_rdata1),
    .d_rd(1'b0), .d_wr(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_done(d_done1), .d_rdata(d_rdata1), .d_err(d_err1),
    .stall_if(stall_if1), .stall_mem(stall_mem1),
    .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1),
    .ram_wdata(ram_wdata1), .ram_rdata(32'h2A2A0001)
`ifdef MEM_PORT_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-timing model: a grant sampled at the end of cycle t0 gives
  // ram_en in cycles t0+1..t0+W, done in t0+W+1, next sample at end of t0+W+2.
  initial begin : model
    int   n;
    int   k;
    bit   mvalid;
    bit   busy;
    int   t0;
    bit   t_mem;
    bit   t_we;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic [31:0] m_if_rdata;
    logic [31:0] m_d_rdata;
    bit   m_err;
    int   m_cnt;
    bit   e_en;
    bit   e_ifd;
    bit   e_dd;
    n = 0; k = 0; mvalid = 0; busy = 0; t0 = 0; t_mem = 0; t_we = 0;
    t_addr = '0; t_wdata = '0; m_if_rdata = '0; m_d_rdata = '0; m_err = 0; m_cnt = 0;
    forever begin
      @(negedge clk);
      k = n - t0;
      if (mvalid) begin
        e_en  = busy && (k >= 1) && (k <= W);
        e_ifd = busy && (k == W + 1) && !t_mem;
        e_dd  = busy && (k == W + 1) && t_mem;
        chk("m_ram_en",    64'(ram_en),    64'(e_en));
        chk("m_ram_we",    64'(ram_we),    64'(e_en && t_we));
        chk("m_if_done",   64'(if_done),   64'(e_ifd));
        chk("m_d_done",    64'(d_done),    64'(e_dd));
        chk("m_if_rdata",  64'(if_rdata),  64'(m_if_rdata));
        chk("m_d_rdata",   64'(d_rdata),   64'(m_d_rdata));
        chk("m_d_err",     64'(d_err),     64'(m_err));
        chk("m_stall_if",  64'(stall_if),  64'(if_req && !e_ifd));
        chk("m_stall_mem", 64'(stall_mem), 64'((d_rd || d_wr) && !e_dd));
        if (e_en) chk("m_ram_addr", 64'(ram_addr), 64'(t_addr));
        if (e_en && t_we) chk("m_ram_wdata", 64'(ram_wdata), 64'(t_wdata));
`ifdef MEM_PORT_ARB_STATS_EN
        chk("m_conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
`endif
      end
      if (busy) begin
        if (k == W && !t_we) begin
          if (t_mem) m_d_rdata = ram_rdata;
          else       m_if_rdata = ram_rdata;
        end
        if (k == W + 1) busy = 0;
      end else if (d_rd || d_wr || if_req) begin
        busy  = 1;
        t0    = n;
        t_mem = d_rd || d_wr;
        if (t_mem) begin
          t_addr  = d_addr;
          t_we    = d_wr;
          t_wdata = d_wdata;
          if (d_rd && d_wr) m_err = 1;
          if (if_req && m_cnt < 65535) m_cnt = m_cnt + 1;
        end else begin
          t_addr = if_addr;
          t_we   = 0;
        end
      end
      if (rst) begin
        busy = 0; m_if_rdata = '0; m_d_rdata = '0; m_err = 0; m_cnt = 0;
        mvalid = 1;
      end
      n++;
    end
  end

  // WAIT_CYCLES=1 instance: held fetch request gives en in c%3==1, done in c%3==2.
  initial begin : w1_test
    rst1 = 1'b1;
    if_req1 = 1'b0;
    step();
    step();
    rst1 = 1'b0;
    if_req1 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("w1_ram_en",  64'(ram_en1),  64'((i % 3) == 1));
      chk("w1_if_done", 64'(if_done1), 64'((i % 3) == 2));
      chk("w1_ram_we",  64'(ram_we1),  64'(0));
      chk("w1_d_done",  64'(d_done1),  64'(0));
      if ((i % 3) == 1) chk("w1_ram_addr", 64'(ram_addr1), 64'h10);
      if ((i % 3) == 2) chk("w1_if_rdata", 64'(if_rdata1), 64'h2A2A0001);
      step();
    end
    if_req1 = 1'b0;
    w1_done = 1'b1;
  end

  initial begin : stim
    logic [3:0] en4;
    logic [3:0] dn4;
    logic [3:0] st4;
    logic [3:0] er4;
    logic [7:0] en8;
    logic [7:0] dd8;
    logic [7:0] id8;
    logic [7:0] st8;
    logic [5:0] en6;
    logic [5:0] id6;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_rd = 1'b0; d_wr = 1'b0;
    d_addr = '0; d_wdata = '0; ram_rdata = '0;
    step();
    step();
    // Reset state
    @(negedge clk);
    chk("rst_ram_en",    64'(ram_en),    64'(0));
    chk("rst_ram_we",    64'(ram_we),    64'(0));
    chk("rst_ram_addr",  64'(ram_addr),  64'(0));
    chk("rst_ram_wdata", 64'(ram_wdata), 64'(0));
    chk("rst_if_done",   64'(if_done),   64'(0));
    chk("rst_d_done",    64'(d_done),    64'(0));
    chk("rst_if_rdata",  64'(if_rdata),  64'(0));
    chk("rst_d_rdata",   64'(d_rdata),   64'(0));
    chk("rst_d_err",     64'(d_err),     64'(0));
    step();
    rst = 1'b0;

    // IF read
    en4 = 4'b0110; dn4 = 4'b1000; st4 = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin if_req = 1'b1; if_addr = 32'h40; ram_rdata = 32'h20080005; end
      @(negedge clk);
      chk("if_ram_en",   64'(ram_en),   64'(en4[i]));
      chk("if_done_pat", 64'(if_done),  64'(dn4[i]));
      chk("if_stall",    64'(stall_if), 64'(st4[i]));
      if (en4[i]) chk("if_ram_addr", 64'(ram_addr), 64'h40);
      step();
    end
    if_req = 1'b0;
    @(negedge clk);
    chk("if_rdata_val", 64'(if_rdata), 64'h20080005);
    step();

    // Conflict: MEM load and IF fetch together
    en8 = 8'b01100110; dd8 = 8'b00001000; id8 = 8'b10000000; st8 = 8'b01111111;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        if_req = 1'b1; if_addr = 32'h44; d_rd = 1'b1; d_addr = 32'h200;
        ram_rdata = 32'h0BADF00D;
      end
      if (i == 4) begin d_rd = 1'b0; ram_rdata = 32'h8C020004; end
      @(negedge clk);
      chk("cf_ram_en",  64'(ram_en),   64'(en8[i]));
      chk("cf_d_done",  64'(d_done),   64'(dd8[i]));
      chk("cf_if_done", 64'(if_done),  64'(id8[i]));
      chk("cf_stall",   64'(stall_if), 64'(st8[i]));
      step();
    end
    if_req = 1'b0;
    @(negedge clk);
    chk("cf_d_rdata",  64'(d_rdata),  64'h0BADF00D);
    chk("cf_if_rdata", 64'(if_rdata), 64'h8C020004);
`ifdef MEM_PORT_ARB_STATS_EN
    chk("cf_conflict_cnt", 64'(conflict_cnt), 64'd1);
`endif
    step();

    // Store
    en4 = 4'b0110; dn4 = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        d_wr = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; ram_rdata = 32'h12345678;
      end
      @(negedge clk);
      chk("st_ram_en", 64'(ram_en), 64'(en4[i]));
      chk("st_ram_we", 64'(ram_we), 64'(en4[i]));
      chk("st_d_done", 64'(d_done), 64'(dn4[i]));
      if (en4[i]) begin
        chk("st_ram_addr",  64'(ram_addr),  64'h100);
        chk("st_ram_wdata", 64'(ram_wdata), 64'hDEADBEEF);
      end
      step();
    end
    d_wr = 1'b0;
    @(negedge clk);
    chk("st_d_rdata_kept", 64'(d_rdata), 64'h0BADF00D);
    step();

    // Illegal request: rd and wr together
    er4 = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        d_rd = 1'b1; d_wr = 1'b1; d_addr = 32'h104; d_wdata = 32'hCAFE0001;
      end
      @(negedge clk);
      chk("il_ram_we", 64'(ram_we), 64'(en4[i]));
      chk("il_d_done", 64'(d_done), 64'(dn4[i]));
      chk("il_d_err",  64'(d_err),  64'(er4[i]));
      if (en4[i]) chk("il_ram_wdata", 64'(ram_wdata), 64'hCAFE0001);
      step();
    end
    d_rd = 1'b0; d_wr = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("il_d_err_sticky", 64'(d_err),   64'(1));
    chk("il_d_rdata_kept", 64'(d_rdata), 64'h0BADF00D);
    step();

    // Reset in the first ACCESS cycle, then a fresh fetch
    en6 = 6'b011010; id6 = 6'b100000;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin if_req = 1'b1; if_addr = 32'h80; ram_rdata = 32'h11112222; end
      if (i == 1) rst = 1'b1;
      if (i == 2) rst = 1'b0;
      @(negedge clk);
      chk("rm_ram_en",  64'(ram_en),  64'(en6[i]));
      chk("rm_if_done", 64'(if_done), 64'(id6[i]));
      if (i == 2) begin
        chk("rm_d_err_clr",    64'(d_err),    64'(0));
        chk("rm_if_rdata_clr", 64'(if_rdata), 64'(0));
        chk("rm_d_rdata_clr",  64'(d_rdata),  64'(0));
      end
      step();
    end
    if_req = 1'b0;
    @(negedge clk);
    chk("rm_if_rdata", 64'(if_rdata), 64'h11112222);
    step();

    for (int i = 0; i < 20; i++) begin
      if (!w1_done) step();
    end
    chk("w1_finished", 64'(w1_done), 64'(1));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
